// File: rtl/pc_pkg.sv
// pc_pkg -- shared definitions for the program-counter generator slice.
//   PC_RESET_VEC / PC_EXC_VEC : default 32-bit reset and exception vectors
//   pcsel_e                   : which source wins the PC update this cycle
//   align_bits()              : number of PC low bits that must be zero for a
//                               given sequential increment
package pc_pkg;

  localparam logic [31:0] PC_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] PC_EXC_VEC   = 32'h0000_4180;

  typedef enum logic [2:0] {
    PCSEL_EXC,
    PCSEL_ERET,
    PCSEL_JUMP,
    PCSEL_SEQ,
    PCSEL_HOLD
  } pcsel_e;

  // An increment of 1 needs no alignment, which $clog2 already yields as 0.
  function automatic int align_bits(input int inc);
    return (inc <= 1) ? 0 : $clog2(inc);
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if -- fetch-side control/status bundle of pc_gen.
//   master : pipeline side, drives redirect/stall/RAS requests, reads PC state
//   slave  : pc_gen side
interface pc_gen_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             jump_flush;
  logic [WIDTH-1:0] jump_target;
  logic             eret_m;
  logic             exc_m;
  logic [WIDTH-1:0] exc_epc;
  logic             ras_push;
  logic [WIDTH-1:0] ras_push_addr;
  logic             ras_pop;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus;
  logic [WIDTH-1:0] epc;
  logic             exl;
  logic             adel;
  logic [WIDTH-1:0] ras_top;
  logic             ras_empty;
  logic             ras_full;

  modport master (
    output en, jump_flush, jump_target, eret_m, exc_m, exc_epc,
           ras_push, ras_push_addr, ras_pop,
    input  pc, pc_plus, epc, exl, adel, ras_top, ras_empty, ras_full
  );

  modport slave (
    input  en, jump_flush, jump_target, eret_m, exc_m, exc_epc,
           ras_push, ras_push_addr, ras_pop,
    output pc, pc_plus, epc, exl, adel, ras_top, ras_empty, ras_full
  );
endinterface

// File: rtl/pc_ras.sv
// pc_ras -- circular return-address stack.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push, push_addr : push a return address (oldest entry lost when full)
//   pop             : pop top entry (ignored when empty)
//   push+pop        : replace the top entry in place
//   top             : entry below the write pointer, 0 when empty
//   empty / full    : count == 0 / count == RAS_DEPTH
module pc_ras #(
  parameter int RAS_DEPTH = 4,
  parameter int WIDTH     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_addr,
  input  logic             pop,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);
  localparam int PW = $clog2(RAS_DEPTH);

  logic [PW-1:0]    wp_reg;
  logic [PW:0]      cnt_reg;
  logic [WIDTH-1:0] entry_reg [RAS_DEPTH];
  logic [PW-1:0]    wp_m1;
  logic             has;
  logic             do_push;
  logic             do_repl;
  logic             do_pop;

  // Depth is a power of two, so the pointer wraps for free.
  assign wp_m1 = wp_reg - PW'(1);
  assign has   = (cnt_reg != '0);
  assign empty = ~has;
  assign full  = (cnt_reg == (PW+1)'(RAS_DEPTH));

  // A push+pop on an empty stack degrades to a plain push.
  assign do_push = push & (~pop | ~has);
  assign do_repl = push & pop & has;
  assign do_pop  = pop & ~push & has;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_reg  <= '0;
      cnt_reg <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) entry_reg[i] <= '0;
    end else if (do_push) begin
      entry_reg[wp_reg] <= push_addr;
      wp_reg            <= wp_reg + PW'(1);
      if (!full) cnt_reg <= cnt_reg + 1'b1;
    end else if (do_repl) begin
      entry_reg[wp_m1] <= push_addr;
    end else if (do_pop) begin
      wp_reg  <= wp_m1;
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign top = has ? entry_reg[wp_m1] : '0;

endmodule

// File: rtl/pc_gen.sv
// pc_gen -- fetch program counter with prioritised redirect, EPC/EXL state
// and a return-address stack.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pc_gen_if.slave (stall/redirect/RAS requests in;
//                pc, pc_plus, epc, exl, adel, RAS status out)
// Priority per edge: exception > ERET > jump/branch > sequential > hold.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(PC_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(PC_EXC_VEC),
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4
) (
  input logic      clk,
  input logic      rst_n,
  pc_gen_if.slave  bus
);
  localparam int               ALIGN    = align_bits(INC);
  localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((1 << ALIGN) - 1);

  pcsel_e           sel;
  logic [WIDTH-1:0] pc_reg,   pc_next;
  logic [WIDTH-1:0] epc_reg,  epc_next;
  logic             exl_reg,  exl_next;
  logic             adel_reg, adel_next;
  logic             ras_block;

  always_comb begin
    if (bus.exc_m)           sel = PCSEL_EXC;
    else if (bus.eret_m)     sel = PCSEL_ERET;
    else if (bus.jump_flush) sel = PCSEL_JUMP;
    else if (bus.en)         sel = PCSEL_SEQ;
    else                     sel = PCSEL_HOLD;
  end

  always_comb begin
    pc_next   = pc_reg;
    epc_next  = epc_reg;
    exl_next  = exl_reg;
    adel_next = 1'b0;
    case (sel)
      PCSEL_EXC: begin
        pc_next = EXC_VEC;
        // Nested exceptions keep the original faulting PC.
        if (!exl_reg) begin
          epc_next = bus.exc_epc;
          exl_next = 1'b1;
        end
      end
      PCSEL_ERET: begin
        pc_next  = epc_reg;
        exl_next = 1'b0;
      end
      PCSEL_JUMP: begin
        pc_next   = bus.jump_target & ~LOW_MASK;
        adel_next = |(bus.jump_target & LOW_MASK);
      end
      PCSEL_SEQ: pc_next = pc_reg + WIDTH'(INC);
      default:   pc_next = pc_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg   <= RESET_VEC;
      epc_reg  <= '0;
      exl_reg  <= 1'b0;
      adel_reg <= 1'b0;
    end else begin
      pc_reg   <= pc_next;
      epc_reg  <= epc_next;
      exl_reg  <= exl_next;
      adel_reg <= adel_next;
    end
  end

  assign bus.pc      = pc_reg;
  assign bus.pc_plus = pc_reg + WIDTH'(INC);
  assign bus.epc     = epc_reg;
  assign bus.exl     = exl_reg;
  assign bus.adel    = adel_reg;

  // Exception entry/return flush the front end, so RAS traffic that cycle is
  // from squashed instructions.
  assign ras_block = bus.exc_m | bus.eret_m;

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .WIDTH     (WIDTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.ras_push & ~ras_block),
    .push_addr (bus.ras_push_addr),
    .pop       (bus.ras_pop & ~ras_block),
    .top       (bus.ras_top),
    .empty     (bus.ras_empty),
    .full      (bus.ras_full)
  );

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;
  logic clk;
  logic rst_n;

  pc_gen_if #(.WIDTH(32)) bus ();
  pc_gen_if #(.WIDTH(8))  bus8 ();

  pc_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pc_gen #(
    .WIDTH     (8),
    .RESET_VEC (8'hFC),
    .EXC_VEC   (8'h80),
    .INC       (4),
    .RAS_DEPTH (4)
  ) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;
  int cyc    = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc;
  bit          m_exl, m_adel;
  logic [31:0] m_ras[$];
  logic [7:0]  m8_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 32'h0000_3000;
    m_epc  = 32'h0;
    m_exl  = 1'b0;
    m_adel = 1'b0;
    m_ras.delete();
    m8_pc  = 8'hFC;
  endtask

  function automatic logic [31:0] m_top();
    if (m_ras.size() == 0) return 32'h0;
    return m_ras[m_ras.size()-1];
  endfunction

  task automatic check_all();
    chk("pc",        bus.pc,        m_pc);
    chk("pc_plus",   bus.pc_plus,   32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000));
    chk("epc",       bus.epc,       m_epc);
    chk("exl",       32'(bus.exl),  32'(m_exl));
    chk("adel",      32'(bus.adel), 32'(m_adel));
    chk("ras_top",   bus.ras_top,   m_top());
    chk("ras_empty", 32'(bus.ras_empty), 32'(m_ras.size() == 0));
    chk("ras_full",  32'(bus.ras_full),  32'(m_ras.size() == 4));
    chk("pc8",       32'(bus8.pc),  32'(m8_pc));
  endtask

  // One clock: predict from current inputs, clock, then compare everything.
  task automatic cycle();
    logic [31:0] n_pc, n_epc, t;
    bit          n_exl, n_adel;
    n_pc   = m_pc;
    n_epc  = m_epc;
    n_exl  = m_exl;
    n_adel = 1'b0;
    if (bus.exc_m) begin
      n_pc = 32'h0000_4180;
      if (!m_exl) begin
        n_epc = bus.exc_epc;
        n_exl = 1'b1;
      end
    end else if (bus.eret_m) begin
      n_pc  = m_epc;
      n_exl = 1'b0;
    end else if (bus.jump_flush) begin
      t      = bus.jump_target;
      n_pc   = t - (t % 4);
      n_adel = (t % 4) != 0;
    end else if (bus.en) begin
      n_pc = 32'((64'(m_pc) + 64'd4) % 64'h1_0000_0000);
    end
    if (!(bus.exc_m || bus.eret_m)) begin
      if (bus.ras_push && bus.ras_pop && m_ras.size() > 0) begin
        m_ras[m_ras.size()-1] = bus.ras_push_addr;
      end else if (bus.ras_push) begin
        m_ras.push_back(bus.ras_push_addr);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end else if (bus.ras_pop && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
    end
    if (bus8.en) m8_pc = 8'((int'(m8_pc) + 4) % 256);
    @(posedge clk);
    #1;
    m_pc   = n_pc;
    m_epc  = n_epc;
    m_exl  = n_exl;
    m_adel = n_adel;
    cyc++;
    $display("cyc %0d: pc=%h epc=%h exl=%0d adel=%0d ras_top=%h empty=%0d full=%0d pc8=%h",
             cyc, bus.pc, bus.epc, bus.exl, bus.adel, bus.ras_top,
             bus.ras_empty, bus.ras_full, bus8.pc);
    check_all();
  endtask

  task automatic idle();
    bus.en = 0; bus.jump_flush = 0; bus.jump_target = 0;
    bus.eret_m = 0; bus.exc_m = 0; bus.exc_epc = 0;
    bus.ras_push = 0; bus.ras_push_addr = 0; bus.ras_pop = 0;
  endtask

  initial begin
    logic [31:0] a [5];
    idle();
    bus8.en = 0; bus8.jump_flush = 0; bus8.jump_target = 0;
    bus8.eret_m = 0; bus8.exc_m = 0; bus8.exc_epc = 0;
    bus8.ras_push = 0; bus8.ras_push_addr = 0; bus8.ras_pop = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check_all();

    // Run a little, then reset asynchronously mid-cycle.
    bus.en = 1;
    repeat (2) cycle();
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_pc", bus.pc, 32'h0000_3000);
    chk("async_rst_pc8", 32'(bus8.pc), 32'h0000_00FC);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check_all();
    chk("rst_exl", 32'(bus.exl), 32'h0);
    chk("rst_empty", 32'(bus.ras_empty), 32'h1);

    // Sequential advance
    cycle(); chk("seq1", bus.pc, 32'h0000_3004);
    cycle(); chk("seq2", bus.pc, 32'h0000_3008);
    cycle(); chk("seq3", bus.pc, 32'h0000_300C);

    // Redirect overrides a stall; misaligned target raises adel for one cycle
    bus.en = 0; bus.jump_flush = 1; bus.jump_target = 32'h0000_3402;
    cycle(); chk("jmp_pc", bus.pc, 32'h0000_3400); chk("jmp_adel", 32'(bus.adel), 32'h1);
    bus.jump_flush = 0;
    cycle(); chk("hold_pc", bus.pc, 32'h0000_3400); chk("adel_drop", 32'(bus.adel), 32'h0);

    // Exception / nested exception / ERET
    bus.jump_flush = 1; bus.jump_target = 32'h0000_3010;
    cycle(); chk("jmp_aligned_adel", 32'(bus.adel), 32'h0);
    bus.jump_flush = 0; bus.exc_m = 1; bus.exc_epc = 32'h0000_300C;
    cycle(); chk("exc_pc", bus.pc, 32'h0000_4180); chk("exc_epc", bus.epc, 32'h0000_300C);
    bus.exc_epc = 32'h0000_5000;
    cycle(); chk("nested_epc", bus.epc, 32'h0000_300C);
    bus.exc_m = 0; bus.eret_m = 1;
    cycle(); chk("eret_pc", bus.pc, 32'h0000_300C); chk("eret_exl", 32'(bus.exl), 32'h0);

    // Simultaneous requests
    bus.exc_m = 1; bus.eret_m = 1; bus.jump_flush = 1; bus.en = 1;
    bus.jump_target = 32'h0000_3800; bus.exc_epc = 32'h0000_3020;
    cycle(); chk("all_pc", bus.pc, 32'h0000_4180);
    bus.exc_m = 0; bus.en = 0;
    cycle(); chk("eret_jmp_pc", bus.pc, 32'h0000_3020);
    idle();

    // RAS overflow, pops, underflow, replace
    for (int i = 0; i < 5; i++) a[i] = 32'h0000_1000 + 32'(i + 1) * 32'h10;
    bus.ras_push = 1;
    for (int i = 0; i < 5; i++) begin
      bus.ras_push_addr = a[i];
      cycle();
    end
    chk("ras_full5", 32'(bus.ras_full), 32'h1); chk("ras_top5", bus.ras_top, a[4]);
    bus.ras_push = 0; bus.ras_pop = 1;
    cycle(); chk("pop1", bus.ras_top, a[3]);
    cycle(); chk("pop2", bus.ras_top, a[2]);
    cycle(); chk("pop3", bus.ras_top, a[1]);
    cycle(); chk("pop4_empty", 32'(bus.ras_empty), 32'h1);
    cycle(); chk("pop5_top", bus.ras_top, 32'h0);
    bus.ras_pop = 0; bus.ras_push = 1;
    bus.ras_push_addr = 32'h0000_2000; cycle();
    bus.ras_push_addr = 32'h0000_2004; cycle();
    bus.ras_pop = 1; bus.ras_push_addr = 32'h0000_2ABC;
    cycle(); chk("repl_top", bus.ras_top, 32'h0000_2ABC);
    bus.ras_push = 0;
    cycle(); chk("repl_cnt", bus.ras_top, 32'h0000_2000);
    cycle(); chk("repl_empty", 32'(bus.ras_empty), 32'h1);
    idle();

    // 8-bit wrap
    chk("wrap0", 32'(bus8.pc), 32'h0000_00FC);
    bus8.en = 1;
    cycle(); chk("wrap1", 32'(bus8.pc), 32'h0000_0000);
    cycle(); chk("wrap2", 32'(bus8.pc), 32'h0000_0004);
    bus8.en = 0;

    // Randomised traffic against the model
    for (int n = 0; n < 300; n++) begin
      bus.en            = ($urandom % 4) != 0;
      bus.jump_flush    = ($urandom % 6) == 0;
      bus.jump_target   = $urandom;
      bus.exc_m         = ($urandom % 12) == 0;
      bus.eret_m        = ($urandom % 12) == 0;
      bus.exc_epc       = $urandom;
      bus.ras_push      = ($urandom % 3) == 0;
      bus.ras_pop       = ($urandom % 3) == 0;
      bus.ras_push_addr = $urandom;
      bus8.en           = ($urandom % 2) == 0;
      cycle();
    end
    idle();
    bus8.en = 0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the pipelined MIPS core. It is the successor of the single fixed-width PC register.
- Holds the fetch PC and applies a prioritised redirect: exception, then ERET, then jump/branch flush, then sequential advance, then hold.
- Owns the EPC/EXL state.
- Includes a small circular return-address stack (RAS) that the fetch stage uses for return prediction.

Parameters:
- WIDTH, 32: PC / address width in bits (≥ 8).
- RESET_VEC, 32'h0000_3000: PC value after reset.
- EXC_VEC, 32'h0000_4180: exception handler entry address.
- INC, 4: sequential increment in bytes (power of 2).
- RAS_DEPTH, 4: number of RAS entries (power of 2, ≥ 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  fetch advance (low = stall).
- jump_flush  in  1  branch/jump redirect.
- jump_target  in  WIDTH  target for jump_flush.
- eret_m  in  1  ERET retiring in the M stage.
- exc_m  in  1  exception raised in the M stage.
- exc_epc  in  WIDTH  faulting-instruction PC, sampled on exc_m.
- ras_push  in  1  call fetched; push ras_push_addr.
- ras_push_addr  in  WIDTH  return address.
- ras_pop  in  1  return fetched; pop.
- pc  out  WIDTH  current fetch PC.
- pc_plus  out  WIDTH  pc + INC (combinational).
- epc  out  WIDTH  exception PC register.
- exl  out  1  exception level flag.
- adel  out  1  one-cycle pulse: misaligned redirect target was loaded.
- ras_top  out  WIDTH  top-of-stack value (0 when empty).
- ras_empty  out  1  count == 0.
- ras_full  out  1  count == RAS_DEPTH.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n low, asynchronous) sets:
  - pc = RESET_VEC, epc = 0, exl = 0, adel = 0.
  - RAS count = 0, RAS pointer = 0, all RAS entries = 0.
- Reset asserted mid-operation discards all pending state. The first edge after release applies normal priority.
- PC update on each rising edge, first match wins:
  1. exc_m: pc ← EXC_VEC. If exl == 0, epc ← exc_epc and exl ← 1. If exl == 1 (nested exception), epc and exl are unchanged.
  2. eret_m: pc ← epc; exl ← 0. Applies even if exl is already 0.
  3. jump_flush: pc ← jump_target with bits [log2(INC)-1:0] forced to 0.
  4. en: pc ← pc + INC, wrapping modulo 2^WIDTH (all-ones region wraps to 0).
  5. otherwise: hold.
- Redirects (priorities 1–3) override a stall (en = 0), matching the existing pipeline contract.
- adel is registered. It is 1 for exactly the cycle after a jump_flush load whose target had nonzero low bits, and only if that jump won priority. Otherwise 0.
- Latency: a redirect presented in cycle N appears on pc in cycle N+1. pc_plus follows pc combinationally.
- RAS is a circular buffer with a write pointer wp and a count cnt. It is independent of en and of the redirects, except that exc_m or eret_m in the same cycle suppresses RAS ops.
  - push only: entry[wp] ← ras_push_addr; wp++. cnt saturates at RAS_DEPTH; on overflow the oldest entry is silently overwritten.
  - pop only: if cnt > 0, wp-- and cnt--. If cnt == 0, no operation.
  - push and pop together: entry[wp-1] ← ras_push_addr; wp and cnt unchanged. If cnt == 0, treat as push only.
  - ras_top = entry[wp-1] when cnt > 0, else 0 (combinational).

Decomposition:
- Shared package pc_pkg holds:
  - RESET_VEC and EXC_VEC default constants.
  - redirect-source enum: PCSEL_EXC, PCSEL_ERET, PCSEL_JUMP, PCSEL_SEQ, PCSEL_HOLD.
  - clog2-based ALIGN_BITS helper.
- One sub-module, pc_ras (RAS_DEPTH, WIDTH), contains the circular stack and its pointer/count logic.
- pc_gen keeps the PC/EPC/EXL registers and the priority mux.

Test Plan:
- Reset: rst_n low mid-cycle, then high, then en = 1 for 3 cycles → pc = 3000 immediately; then 3004, 3008, 300C. epc = 0, exl = 0, ras_empty = 1.
- Stall vs. redirect: en = 0, jump_flush = 1, jump_target = 0x3402 → next pc = 0x3400, adel = 1 for one cycle. Then en = 0 with no redirect → pc holds at 0x3400.
- Exception/ERET: pc = 0x3010; exc_m with exc_epc = 0x300C → pc = 0x4180, epc = 0x300C, exl = 1. A second exc_m with exc_epc = 0x5000 → epc stays 0x300C. eret_m → pc = 0x300C, exl = 0.
- Simultaneous: exc_m, eret_m, jump_flush and en all high → pc = EXC_VEC. With only eret_m and jump_flush → pc = epc.
- RAS: 5 pushes of A1..A5 with RAS_DEPTH = 4 → ras_full, ras_top = A5. Then 4 pops → tops read A4, A3, A2, then ras_empty. A 5th pop is a no-op with ras_top = 0. A push+pop with cnt = 2 replaces the top and cnt stays 2.
- Wrap: WIDTH = 8, RESET_VEC = 8'hFC, en = 1 → pc = FC, then 00, then 04.
